// File: rtl/mp_types_pkg.sv
// Shared precision types and element-width helpers for the mixed-precision datapath.
package mp_types;

  typedef enum logic [1:0] {
    PREC_INT8 = 2'b00,
    PREC_FP16 = 2'b01,
    PREC_FP32 = 2'b10,
    PREC_INT4 = 2'b11
  } prec_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } unpack_state_e;

  localparam int W_INT4 = 4;
  localparam int W_INT8 = 8;
  localparam int W_FP16 = 16;
  localparam int W_FP32 = 32;

  function automatic int elem_width(input prec_e prec);
    case (prec)
      PREC_INT4: return W_INT4;
      PREC_INT8: return W_INT8;
      PREC_FP16: return W_FP16;
      default:   return W_FP32;
    endcase
  endfunction

endpackage

// File: rtl/mp_lane_unpacker_extract.sv
// Combinational element selector: picks element idx out of a packed word and widens it to a lane.
module mp_elem_extract
  import mp_types::*;
#(
  parameter int W_BUS      = 64,
  parameter int W_OUT      = 32,
  parameter int SIGNED_INT = 1,
  parameter int IDX_W      = $clog2(W_BUS / 4)
) (
  input  logic [W_BUS-1:0] word,
  input  prec_e            prec,
  input  logic [IDX_W-1:0] idx,
  output logic [W_OUT-1:0] elem
);

  localparam int SH_W = $clog2(W_BUS);

  logic [SH_W-1:0]  shamt;
  logic [W_OUT-1:0] raw;

  // Integer lanes carry their sign into the upper bits; FP16 is zero-padded without conversion.
  function automatic logic [W_OUT-1:0] widen(input logic [W_OUT-1:0] val, input prec_e p);
    logic signed [3:0]       s4;
    logic signed [7:0]       s8;
    logic signed [W_OUT-1:0] ext;
    s4  = val[3:0];
    s8  = val[7:0];
    ext = '0;
    case (p)
      PREC_INT4: begin
        ext = W_OUT'(s4);
        return (SIGNED_INT != 0) ? ext : W_OUT'(val[3:0]);
      end
      PREC_INT8: begin
        ext = W_OUT'(s8);
        return (SIGNED_INT != 0) ? ext : W_OUT'(val[7:0]);
      end
      PREC_FP16: return W_OUT'(val[15:0]);
      default:   return val;
    endcase
  endfunction

  always_comb begin
    case (prec)
      PREC_INT4: shamt = SH_W'(idx) << 2;
      PREC_INT8: shamt = SH_W'(idx) << 3;
      PREC_FP16: shamt = SH_W'(idx) << 4;
      default:   shamt = SH_W'(idx) << 5;
    endcase
  end

  assign raw  = W_OUT'(word >> shamt);
  assign elem = widen(raw, prec);

endmodule

// File: rtl/mp_lane_unpacker.sv
// Streaming unpacker: holds one packed word and emits its elements LSB-first, one per handshake.
module mp_lane_unpacker
  import mp_types::*;
#(
  parameter int W_BUS      = 64,
  parameter int W_OUT      = 32,
  parameter int SIGNED_INT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W_BUS-1:0]             in_data,
  input  logic [1:0]                   in_prec,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W_OUT-1:0]             out_data,
  output logic [1:0]                   out_prec,
  output logic [$clog2(W_BUS/4)-1:0]   out_idx,
  output logic                         out_last
);

  localparam int IDX_W = $clog2(W_BUS / 4);

  unpack_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_p0, idx_d, last_idx;
  logic [W_BUS-1:0] data_p0;
  prec_e            prec_p0;
  logic [W_OUT-1:0] elem;
  logic             fire, load;

  assign last_idx  = IDX_W'(W_BUS / elem_width(prec_p0) - 1);
  assign out_valid = (state_q == ST_EMIT);
  assign out_last  = out_valid && (idx_p0 == last_idx);
  assign fire      = out_valid && out_ready;
  assign in_ready  = !rst && !abort && ((state_q == ST_IDLE) || (fire && out_last));
  assign load      = in_valid && in_ready;

  // Abort wins over every handshake; a word finishing with a new one waiting reloads in place.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_p0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_d = ST_EMIT;
            idx_d   = '0;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            if (out_last) begin
              state_d = load ? ST_EMIT : ST_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_p0 + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Stage p0: control state, element counter and word precision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_p0  <= '0;
      prec_p0 <= PREC_INT8;
    end else begin
      state_q <= state_d;
      idx_p0  <= idx_d;
      if (load) prec_p0 <= prec_e'(in_prec);
    end
  end

  // Stage p0: held word payload
  always_ff @(posedge clk) begin
    if (load) data_p0 <= in_data;
  end

  mp_elem_extract #(
    .W_BUS     (W_BUS),
    .W_OUT     (W_OUT),
    .SIGNED_INT(SIGNED_INT),
    .IDX_W     (IDX_W)
  ) u_extract (
    .word(data_p0),
    .prec(prec_p0),
    .idx (idx_p0),
    .elem(elem)
  );

  assign out_data = out_valid ? elem : '0;
  assign out_prec = prec_p0;
  assign out_idx  = idx_p0;

endmodule
